// File: rtl/mold_arbiter.sv
// mold_arbiter: shares one pipelined vector-magnitude (`mold`) unit among N
// requesters. A round-robin arbiter picks one requester per clock and
// registers its vector into the mold operand registers. The winner's ID
// rides a tag delay line that matches the mold pipeline, so each result
// returns to its requester as a one-cycle res_valid pulse.
//
// Handshake: requester i raises req[i] and holds its vector on vec_*[i*W +: W]
// until it is granted. gnt is combinational and one-hot. A transfer happens on
// every rising edge where req[i] & gnt[i] is high. Dropping req before a
// grant has no side effects. The requester must accept res_valid
// unconditionally, because the mold pipeline cannot stall.
module mold_arbiter #(
  parameter  int N   = 4,
  parameter  int W   = 20,
  parameter  int LAT = 8,
  localparam int IW  = (N > 1) ? $clog2(N) : 1,
  localparam int CW  = $clog2(LAT + 2) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] vec_x,
  input  logic [N*W-1:0] vec_y,
  input  logic [N*W-1:0] vec_z,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   m_x,
  output logic [W-1:0]   m_y,
  output logic [W-1:0]   m_z,
  input  logic [W-1:0]   m_mold,
  output logic [N-1:0]   res_valid,
  output logic [W-1:0]   res_data,
  output logic [CW-1:0]  inflight
);

  localparam logic [IW:0]   N_EXT    = (IW + 1)'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Round-robin pointer: the requester searched first on the next cycle.
  logic [IW-1:0] r_rr_ptr;

  // Operand registers feeding the mold unit.
  logic [W-1:0]  r_m_x;
  logic [W-1:0]  r_m_y;
  logic [W-1:0]  r_m_z;

  // Tag delay line. Stage LAT lines up with m_mold for the same operation.
  logic [LAT:0]  r_tag_v;
  logic [IW-1:0] r_tag_id [LAT+1];

  // Result return and occupancy.
  logic [N-1:0]  r_res_valid;
  logic [W-1:0]  r_res_data;
  logic [CW-1:0] r_inflight;

  // Arbitration wires.
  logic [N-1:0]  w_req_rot;
  logic          w_found;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_gnt;
  logic          w_xfer;
  logic          w_ret;
  logic [W-1:0]  w_sel_x;
  logic [W-1:0]  w_sel_y;
  logic [W-1:0]  w_sel_z;

  // Rotate requests so that bit 0 is the requester at r_rr_ptr.
  assign w_req_rot = (req >> r_rr_ptr) | (req << (N_EXT - {1'b0, r_rr_ptr}));

  // Find the first requester at or after the pointer, as an offset from it.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int o = 0; o < N; o++) begin
      if (!w_found && w_req_rot[o]) begin
        w_found = 1'b1;
        w_off   = IW'(o);
      end
    end
  end

  // Convert the offset back to a requester index, modulo N.
  assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_win     = (w_sum >= N_EXT) ? IW'(w_sum - N_EXT) : w_sum[IW-1:0];
  assign w_ptr_nxt = (w_win == LAST_IDX) ? '0 : w_win + IW'(1);

  // No grant is offered while reset is asserted.
  assign w_gnt  = (w_found && !rst) ? (N'(1) << w_win) : '0;
  assign w_xfer = |w_gnt;
  assign gnt    = w_gnt;

  // Select the winner's vector by comparing against constant indices.
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    w_sel_z = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == IW'(i)) begin
        w_sel_x = vec_x[i*W +: W];
        w_sel_y = vec_y[i*W +: W];
        w_sel_z = vec_z[i*W +: W];
      end
    end
  end

  // On a transfer, capture the winner's operands and advance the pointer past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_m_x    <= '0;
      r_m_y    <= '0;
      r_m_z    <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_ptr_nxt;
      r_m_x    <= w_sel_x;
      r_m_y    <= w_sel_y;
      r_m_z    <= w_sel_z;
    end
  end

  // Tag valid bits shift every cycle. Reset drops every in-flight tag, so
  // results still leaving mold after reset are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
    end else begin
      r_tag_v <= {r_tag_v[LAT-1:0], w_xfer};
    end
  end

  // Tag IDs shift alongside the valids. An ID only matters where its valid is set.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_win;
    for (int i = 1; i <= LAT; i++) begin
      r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign w_ret = r_tag_v[LAT];

  // Route the mold output to the tagged requester as a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
    end else if (w_ret) begin
      r_res_valid <= N'(1) << r_tag_id[LAT];
      r_res_data  <= m_mold;
    end else begin
      r_res_valid <= '0;
    end
  end

  // Count operations from issue until their res_valid strobe has been shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_xfer, |r_res_valid})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign m_x       = r_m_x;
  assign m_y       = r_m_y;
  assign m_z       = r_m_z;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign inflight  = r_inflight;

endmodule

// File: tb/tb_mold_arbiter.sv
// tb_mold_arbiter: directed table-driven bench for mold_arbiter with a
// behavioural LAT-stage mold model and an expected-result queue.
module tb_mold_arbiter;

  localparam int N   = 4;
  localparam int W   = 20;
  localparam int LAT = 8;
  localparam int CW  = $clog2(LAT + 2) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] vec_x, vec_y, vec_z;
  logic [N-1:0]   gnt;
  logic [W-1:0]   m_x, m_y, m_z;
  logic [W-1:0]   m_mold;
  logic [N-1:0]   res_valid;
  logic [W-1:0]   res_data;
  logic [CW-1:0]  inflight;

  always #5 clk = ~clk;

  mold_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .vec_x     (vec_x),
    .vec_y     (vec_y),
    .vec_z     (vec_z),
    .gnt       (gnt),
    .m_x       (m_x),
    .m_y       (m_y),
    .m_z       (m_z),
    .m_mold    (m_mold),
    .res_valid (res_valid),
    .res_data  (res_data),
    .inflight  (inflight)
  );

  // ---------------- mold model ----------------
  function automatic logic [W-1:0] isqrt3(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    longint s, r, t;
    s = longint'(a) * longint'(a) + longint'(b) * longint'(b) + longint'(c) * longint'(c);
    r = 0;
    for (int k = 22; k >= 0; k--) begin
      t = r | (longint'(1) << k);
      if (t * t <= s) r = t;
    end
    return W'(r);
  endfunction

  logic [W-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= isqrt3(m_x, m_y, m_z);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign m_mold = pipe[LAT-1];

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           due_q[$];
  int           mdl_inflight = 0;
  int           peak = 0;
  logic [N-1:0] sb_exp_rv;
  logic [W-1:0] sb_exp_rd;
  logic [N-1:0] sb_xfer;
  int           sb_wid;

  // Every falling edge: compare the result strobe and occupancy, then record
  // any transfer that the coming rising edge will perform.
  always @(negedge clk) begin
    sb_exp_rv = '0;
    sb_exp_rd = '0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      sb_exp_rv = N'(1) << id_q[0];
      sb_exp_rd = exp_q.pop_front();
      void'(id_q.pop_front());
      void'(due_q.pop_front());
    end
    check("res_valid", res_valid, sb_exp_rv);
    if (sb_exp_rv != 0) check("res_data", res_data, sb_exp_rd);
    check("inflight", inflight, mdl_inflight);
    check("gnt_onehot0", $onehot0(gnt), 1);
    if (int'(inflight) > peak) peak = int'(inflight);
    if (rst) begin
      exp_q.delete();
      id_q.delete();
      due_q.delete();
      mdl_inflight = 0;
    end else begin
      sb_xfer = req & gnt;
      if (sb_xfer != 0) begin
        sb_wid = 0;
        for (int i = 0; i < N; i++) if (sb_xfer[i]) sb_wid = i;
        exp_q.push_back(isqrt3(vec_x[sb_wid*W +: W], vec_y[sb_wid*W +: W], vec_z[sb_wid*W +: W]));
        id_q.push_back(sb_wid);
        due_q.push_back(cyc + LAT + 2);
        mdl_inflight++;
      end
      if (res_valid != 0) mdl_inflight--;
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N*W-1:0] vx;
    logic [N*W-1:0] vy;
    logic [N*W-1:0] vz;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [N*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic void add(input logic [N-1:0] r, input logic [N-1:0] g,
                              input logic [N*W-1:0] vx, input logic [N*W-1:0] vy,
                              input logic [N*W-1:0] vz);
    vec_t v;
    v.req = r;
    v.gnt = g;
    v.vx  = vx;
    v.vy  = vy;
    v.vz  = vz;
    tbl.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      req   = tbl[i].req;
      vec_x = tbl[i].vx;
      vec_y = tbl[i].vy;
      vec_z = tbl[i].vz;
      @(negedge clk);
      check($sformatf("%s_gnt[%0d]", name, i), gnt, tbl[i].gnt);
      step();
    end
    tbl.delete();
    req = '0;
  endtask

  task automatic drain(input string name);
    req = '0;
    for (int i = 0; i < 40 && due_q.size() != 0; i++) step();
    check({name, "_drained"}, due_q.size(), 0);
    step();
    step();
  endtask

  task automatic pulse_rst(input logic [N-1:0] r);
    rst = 1'b1;
    req = r;
    @(negedge clk);
    check("gnt_during_rst", gnt, 0);
    step();
    rst = 1'b0;
    req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    rst   = 1'b1;
    req   = '1;
    vec_x = '0;
    vec_y = '0;
    vec_z = '0;
    step();
    step();

    // Reset state, with every requester asserting during reset.
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_m_x", m_x, 0);
    check("rst_m_y", m_y, 0);
    check("rst_m_z", m_z, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_inflight", inflight, 0);
    step();
    rst = 1'b0;
    req = '0;

    // Single operation: (3,4,0) returns 5 to requester 0.
    add(4'b0001, 4'b0001, pk(3, 0, 0, 0), pk(4, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b0000, 4'b0000, pk(3, 0, 0, 0), pk(4, 0, 0, 0), pk(0, 0, 0, 0));
    run_tbl("single");
    drain("single");

    // Contention: all four requesters for 8 cycles from a fresh pointer.
    pulse_rst(4'b0000);
    for (int k = 0; k < 8; k++)
      add(4'b1111, 4'(1 << (k % 4)), pk(1, 2, 3, 4), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    run_tbl("contend");
    drain("contend");

    // Back-to-back from requester 2, vectors (0,0,k).
    peak = 0;
    for (int k = 1; k <= 5; k++)
      add(4'b0100, 4'b0100, pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, k, 0));
    run_tbl("b2b");
    drain("b2b");
    check("b2b_peak_inflight", peak, 5);

    // Pointer wrap: grant to 3, then 0 and 3 compete.
    add(4'b1000, 4'b1000, pk(2, 0, 0, 9), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b1001, 4'b0001, pk(2, 0, 0, 9), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b1001, 4'b1000, pk(2, 0, 0, 9), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    run_tbl("wrap");
    drain("wrap");

    // Withdraw: requester 1 asks for one cycle while 3 holds priority.
    add(4'b0100, 4'b0100, pk(0, 11, 1, 2), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b1010, 4'b1000, pk(0, 11, 1, 2), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b1000, 4'b1000, pk(0, 11, 1, 2), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b1000, 4'b1000, pk(0, 11, 1, 2), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b0000, 4'b0000, pk(0, 11, 1, 2), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    run_tbl("withdraw");
    drain("withdraw");

    // Reset mid-flight: 3 ops, reset 4 cycles later, then 20 quiet cycles.
    for (int k = 1; k <= 3; k++)
      add(4'b0001, 4'b0001, pk(k, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      add(4'b0000, 4'b0000, pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    run_tbl("pre_rst");
    pulse_rst(4'b1111);
    repeat (20) step();
    @(negedge clk);
    check("inflight_after_rst", inflight, 0);
    step();
    add(4'b0001, 4'b0001, pk(6, 0, 0, 0), pk(8, 0, 0, 0), pk(0, 0, 0, 0));
    add(4'b0000, 4'b0000, pk(6, 0, 0, 0), pk(8, 0, 0, 0), pk(0, 0, 0, 0));
    run_tbl("post_rst");
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mold_arbiter.md
Name: mold_arbiter

Overview:
- Shares one pipelined `mold` unit (vector magnitude, sqrt(x²+y²+z²), 20-bit) among N requesters, e.g. the ray, hit and shading engines.
- Round-robin arbitration; issues at most one vector per clock into the `mold` pipeline.
- Carries the requester ID alongside each vector in a tag delay line and routes each result back to its requester with a one-cycle valid pulse.
- Sits between the requesters and a single `mold` instance; the `mold` unit itself has no backpressure.

Parameters:
- N, 4, number of requesters (2..8).
- W, 20, vector component and result width.
- LAT, 8, `mold` pipeline latency: a value on m_x/m_y/m_z in cycle c gives the corresponding m_mold in cycle c+LAT (LAT ≥ 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request; held high with its vector stable until granted.
- vec_x  in  N*W  requester i's x component at bits [i*W +: W].
- vec_y  in  N*W  y components, same packing.
- vec_z  in  N*W  z components, same packing.
- gnt  out  N  combinational one-hot grant; a transfer occurs on a rising edge where req[i] & gnt[i].
- m_x  out  W  registered x operand to `mold`.
- m_y  out  W  registered y operand to `mold`.
- m_z  out  W  registered z operand to `mold`.
- m_mold  in  W  `mold` result.
- res_valid  out  N  registered one-hot, one-cycle result strobe.
- res_data  out  W  registered result; valid while any res_valid bit is set.
- inflight  out  clog2(LAT+2)+1  registered count of issued, not yet returned, operations.

Behaviour:
- Reset values:
  - rr_ptr = 0.
  - m_x, m_y, m_z = 0.
  - res_valid = 0, res_data = 0, inflight = 0.
  - All tag-line valid bits = 0.
- Arbitration:
  - gnt = first set bit of req, searching from rr_ptr upward with wrap-around.
  - gnt is 0 when req = 0 and is 0 during rst.
  - Purely combinational from req and rr_ptr.
- Transfer edge, winner k:
  - m_x/m_y/m_z <= vector k.
  - rr_ptr <= (k+1) mod N.
  - Tag line stage 0 <= {valid=1, id=k}.
- No transfer:
  - m_x/m_y/m_z hold their values.
  - rr_ptr holds.
  - Stage 0 <= {valid=0}.
- Tag line:
  - LAT+1 stages; shifts every cycle; no stall condition exists.
- Return:
  - When the last tag stage is valid with id j: res_valid <= one-hot(j), res_data <= m_mold.
  - Otherwise res_valid <= 0 and res_data holds.
- Latency: a transfer at edge E gives res_valid high in the cycle after edge E+LAT+1, i.e. exactly LAT+2 cycles after the transfer edge.
- Ordering and throughput:
  - Results return in issue order.
  - Throughput is 1 op/cycle.
  - A requester holding req high is granted every cycle only while it is the sole requester.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0,…; any requester waits at most N-1 cycles.
- inflight:
  - +1 on a transfer, −1 on a res_valid assertion.
  - Both in the same cycle: unchanged.
  - Maximum is LAT+2.
- Requester rules:
  - May drop req without being granted; no side effects.
  - Must accept res_valid unconditionally.
  - vec_* of a non-granted requester are ignored.
- Reset mid-operation:
  - All tag valids cleared, so in-flight results leaving `mold` after reset are discarded.
  - No res_valid for pre-reset transfers; inflight returns to 0.
- rst and req both high on the same edge: no transfer; gnt = 0 during rst.

Test Plan:
- Single op: after rst, req=0001, vec0=(3,4,0) for one cycle → transfer; res_valid=0001 with res_data=5 exactly 10 cycles later (LAT=8); inflight 1 then 0.
- Contention: req=1111 held 8 cycles, vec i = (i+1,0,0) → gnt sequence 0001,0010,0100,1000 repeating; results 1,2,3,4,1,2,3,4 strobed to matching res_valid bits on consecutive cycles.
- Back-to-back single requester: req=0100 held 5 cycles, vectors (0,0,k) for k=1..5 → 5 consecutive res_valid=0100 with res_data 1..5; peak inflight=5.
- Pointer wrap: last grant to 3, then req=1001 → gnt=0001 first, then 1000.
- Reset mid-flight: 3 ops issued, rst pulsed 1 cycle 4 cycles later → no res_valid for the next 20 cycles; inflight=0; a new op (6,8,0) returns 10 after its own 10-cycle latency.
- Idle/withdraw: req=0010 raised and dropped while another requester is granted every cycle → no transfer for requester 1, no spurious res_valid.
